clock_boundary: RTL and testbench

//  Link-retiming stage that models the clock-domain boundary between two ring segments.
//  It accepts one flit word per cycle on port0_ci.
//  It re-emits the word on port0_co after a fixed, parameterised number of clock edges.
//  It normalises idle (invalid) slots to all-zero so no stale payload crosses the boundary.
//  It sits on every inter-ring link of the hierarchical ring.
//  It has no back-pressure: every input slot is delivered in order, nothing is dropped.

---
 rtl/clock_boundary.sv | 53 +++++
 tb/tb_clock_boundary.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clock_boundary.sv
// clock_boundary
//   Link-retiming stage on an inter-ring link of the hierarchical ring. Each cycle one flit word
//   enters, is normalised (invalid slots forced to all-zero), and leaves exactly LATENCY rising
//   edges later. There is no back-pressure, so every slot is delivered in order and none is
//   dropped. An asynchronous reset discards every in-flight word.
//
// Parameters
//   WIDTH    flit word width; bit WIDTH-1 is the valid bit and the rest is payload
//   LATENCY  register stages from port0_ci to port0_co; legal range 1..8
//
// Ports
//   clk       single clock; all state updates on its rising edge
//   rst       asynchronous, active-high reset; clears every stage register
//   port0_ci  incoming flit word  {valid, payload}
//   port0_co  outgoing flit word, same format, driven straight from the last stage register

module clock_boundary #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] port0_ci,
  output logic [WIDTH-1:0] port0_co
);

  // Stage i lives in stage_q[i]; stage_q[LATENCY-1] drives the output.
  logic [LATENCY-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]              stage_d;

  // Idle slots are zeroed on entry so stale payload never crosses the boundary.
  always_comb begin
    stage_d = '0;
    if (port0_ci[WIDTH-1]) begin
      stage_d = port0_ci;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= stage_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Registered output only; no combinational path from port0_ci.
  assign port0_co = stage_q[LATENCY-1];

endmodule

// File: tb/tb_clock_boundary.sv
// Directed bench for clock_boundary: three instances (LATENCY 1, 2, 8) share clock, reset and
// input; each output is compared with hand-derived expectations after every rising edge.

module tb_clock_boundary;

  localparam int unsigned W = 128;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic [W-1:0] dout1;
  logic [W-1:0] dout2;
  logic [W-1:0] dout8;

  int unsigned n_checks;
  int unsigned n_pass;

  clock_boundary #(.WIDTH(W), .LATENCY(1)) u_lat1 (
    .clk      (clk),
    .rst      (rst),
    .port0_ci (din),
    .port0_co (dout1)
  );

  clock_boundary #(.WIDTH(W), .LATENCY(2)) u_lat2 (
    .clk      (clk),
    .rst      (rst),
    .port0_ci (din),
    .port0_co (dout2)
  );

  clock_boundary #(.WIDTH(W), .LATENCY(8)) u_lat8 (
    .clk      (clk),
    .rst      (rst),
    .port0_ci (din),
    .port0_co (dout8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %032x expected %032x", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] vword(input int unsigned p);
    logic [W-1:0] w;
    w        = '0;
    w[31:0]  = p;
    w[W-1]   = 1'b1;
    return w;
  endfunction

  logic [W-1:0] big;
  logic [W-1:0] junk;
  logic [W-1:0] e1, e2, e8;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    din      = '0;
    big      = {1'b1, 127'h0123456789abcdef0123456789abcdef};
    junk     = {1'b1, 127'h55aa55aa_12345678_9abcdef0_ffffffff};

    // Reset asserted between edges with a valid word on the input: stages must hold zero.
    #2;
    rst = 1'b1;
    din = junk;
    #1;
    check("rst_async_l2", dout2, '0);
    check("rst_async_l8", dout8, '0);
    tick();
    check("rst_hold_l1", dout1, '0);
    tick();
    check("rst_hold_l2", dout2, '0);

    // Release between edges, then idle for two edges.
    rst = 1'b0;
    din = '0;
    #1;
    check("post_rst_l2", dout2, '0);
    for (int e = 1; e <= 2; e++) begin
      tick();
      check($sformatf("idle_l2_e%0d", e), dout2, '0);
    end

    // Single valid pulse: appears exactly LATENCY edges after launch on each instance.
    din = big;
    for (int e = 1; e <= 9; e++) begin
      tick();
      din = '0;
      check($sformatf("pulse_l1_e%0d", e), dout1, (e == 1) ? big : '0);
      check($sformatf("pulse_l2_e%0d", e), dout2, (e == 2) ? big : '0);
      check($sformatf("pulse_l8_e%0d", e), dout8, (e == 8) ? big : '0);
    end

    // Invalid slots with payload for three cycles: nothing but zero may emerge.
    din = {1'b0, 127'hdeadbeef};
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) din = '0;
      check($sformatf("mask_l1_e%0d", e), dout1, '0);
      check($sformatf("mask_l2_e%0d", e), dout2, '0);
      check($sformatf("mask_l8_e%0d", e), dout8, '0);
    end

    // Stream 16 back-to-back valid words; word k is sampled at edge k.
    din = vword(1);
    for (int e = 1; e <= 24; e++) begin
      tick();
      din = (e < 16) ? vword(e + 1) : '0;
      e1 = (e >= 1 && e <= 16)         ? vword(e)     : '0;
      e2 = (e - 1 >= 1 && e - 1 <= 16) ? vword(e - 1) : '0;
      e8 = (e - 7 >= 1 && e - 7 <= 16) ? vword(e - 7) : '0;
      check($sformatf("stream_l1_e%0d", e), dout1, e1);
      check($sformatf("stream_l2_e%0d", e), dout2, e2);
      check($sformatf("stream_l8_e%0d", e), dout8, e8);
    end

    // Two valid words in flight, then an asynchronous reset between edges.
    din = vword(32'hA5);
    tick();
    din = vword(32'h5A);
    tick();
    din = '0;
    check("inflight_l2", dout2, vword(32'hA5));
    check("inflight_l1", dout1, vword(32'h5A));
    #3;
    rst = 1'b1;
    #1;
    check("midrst_l1", dout1, '0);
    check("midrst_l2", dout2, '0);
    check("midrst_l8", dout8, '0);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("flushed_l1_e%0d", e), dout1, '0);
      check($sformatf("flushed_l2_e%0d", e), dout2, '0);
      check($sformatf("flushed_l8_e%0d", e), dout8, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
